// File: rtl/fru_filter_controller.sv
// fru_filter_controller: serial-configured sequencer driving one bypass filter unit for a hold window or until cleared.
module fru_filter_controller #(
  parameter int FILTER_SIZE = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int SHADOW_W    = 2*FILTER_SIZE+CNT_WIDTH+2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   CfgShiftEn,
  input  logic                   CfgIn,
  output logic                   CfgOut,
  input  logic                   CfgCommit,
  input  logic                   Trigger,
  input  logic                   Clear,
  output logic [FILTER_SIZE-1:0] BypassEn,
  output logic [FILTER_SIZE-1:0] RegConst,
  output logic                   FruEn,
  output logic                   Armed,
  output logic                   CommitPending
);
  localparam int HI = SHADOW_W-1;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q, cfg_q, pend_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hold;
  logic fru_q, cfgout_q, pending_q, eff_en, leaving, apply_now;
  assign hold = cfg_q[2*FILTER_SIZE+CNT_WIDTH-1:2*FILTER_SIZE];
  // Exit decisions see the config that will be in force once a deferred commit lands
  assign eff_en = pending_q ? pend_q[HI] : cfg_q[HI];
  assign leaving = (state_q == ACTIVE) && (state_d != ACTIVE);
  assign apply_now = CfgCommit && ((state_q != ACTIVE) || leaving);
  assign BypassEn = cfg_q[FILTER_SIZE-1:0];
  assign RegConst = cfg_q[2*FILTER_SIZE-1:FILTER_SIZE];
  assign FruEn = fru_q;
  assign Armed = (state_q == ARMED);
  assign CommitPending = pending_q;
  assign CfgOut = cfgout_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (Clear) state_d = IDLE;
    else if (state_q == IDLE) state_d = cfg_q[HI] ? ARMED : IDLE;
    else if (state_q == ARMED) begin
      if (!cfg_q[HI]) state_d = IDLE;
      else if (Trigger) begin
        state_d = ACTIVE;
        cnt_d = (hold == '0) ? '0 : hold - 1'b1;
      end
    end else if (state_q == ACTIVE) begin
      if (!cfg_q[HI-1]) begin
        if (cnt_q == '0) state_d = eff_en ? ARMED : IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
    end else state_d = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
      cfg_q <= '0;
      pend_q <= '0;
      pending_q <= 1'b0;
      fru_q <= 1'b0;
      cfgout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fru_q <= (state_d == ACTIVE);
      if (CfgShiftEn) begin
        shadow_q <= {shadow_q[HI-1:0], CfgIn};
        cfgout_q <= shadow_q[HI];
      end
      if (apply_now) cfg_q <= shadow_q;
      else if (leaving && pending_q) cfg_q <= pend_q;
      if (CfgCommit && (state_q == ACTIVE) && !leaving) begin
        pend_q <= shadow_q;
        pending_q <= 1'b1;
      end else if (leaving) pending_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fru_filter_controller.sv
// tb_fru_filter_controller: directed checks of config shifting, commit/defer, hold windows, sticky, clear and reset.
module tb_fru_filter_controller;
  logic Clk = 0, Rst, CfgShiftEn, CfgIn, CfgOut, CfgCommit, Trigger, Clear;
  logic [9:0] BypassEn, RegConst;
  logic FruEn, Armed, CommitPending;
  int total = 0, bad = 0;
  logic [29:0] outw, pat;
  int ones;
  fru_filter_controller dut (
    .Clk(Clk), .Rst(Rst), .CfgShiftEn(CfgShiftEn), .CfgIn(CfgIn), .CfgOut(CfgOut),
    .CfgCommit(CfgCommit), .Trigger(Trigger), .Clear(Clear), .BypassEn(BypassEn),
    .RegConst(RegConst), .FruEn(FruEn), .Armed(Armed), .CommitPending(CommitPending)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic shift(input logic [29:0] w, output logic [29:0] o);
    o = '0;
    for (int i = 29; i >= 0; i--) begin
      CfgShiftEn = 1;
      CfgIn = w[i];
      tick();
      o = {o[28:0], CfgOut};
    end
    CfgShiftEn = 0;
    CfgIn = 0;
  endtask
  task automatic commit();
    CfgCommit = 1;
    tick();
    CfgCommit = 0;
  endtask
  task automatic pulse_trig();
    Trigger = 1;
    tick();
    Trigger = 0;
  endtask
  initial begin
    Rst = 1; CfgShiftEn = 0; CfgIn = 0; CfgCommit = 0; Trigger = 0; Clear = 0;
    tick(); tick();
    Rst = 0;
    chk("rst_bypass", BypassEn, 0);
    chk("rst_regconst", RegConst, 0);
    chk("rst_fruen", FruEn, 0);
    chk("rst_armed", Armed, 0);
    chk("rst_pending", CommitPending, 0);
    chk("rst_cfgout", CfgOut, 0);
    // Enable=1 Sticky=0 Hold=3 RegConst=2AA BypassEn=00F
    shift({1'b1, 1'b0, 8'd3, 10'h2AA, 10'h00F}, outw);
    chk("cfg1_out_zero", outw, 0);
    chk("cfg1_hold_before_commit", BypassEn, 0);
    commit();
    chk("cfg1_bypass", BypassEn, 10'h00F);
    chk("cfg1_regconst", RegConst, 10'h2AA);
    chk("cfg1_not_armed_yet", Armed, 0);
    tick();
    chk("cfg1_armed", Armed, 1);
    chk("cfg1_fru_low", FruEn, 0);
    pulse_trig();
    chk("win3_c1", FruEn, 1);
    chk("win3_c1_armed", Armed, 0);
    tick();
    chk("win3_c2", FruEn, 1);
    tick();
    chk("win3_c3", FruEn, 1);
    tick();
    chk("win3_end", FruEn, 0);
    chk("win3_rearmed", Armed, 1);
    Trigger = 1;
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      pat = {pat[28:0], FruEn};
    end
    Trigger = 0;
    chk("level_trig_pattern", pat, 30'b111011101);
    for (int n = 0; n < 10 && !Armed; n++) tick();
    chk("level_trig_back_armed", Armed, 1);
    // Hold=0 behaves as a single cycle; shadow still holds cfg1 and streams it out
    shift({1'b1, 1'b0, 8'd0, 10'h2AA, 10'h00F}, outw);
    chk("cfgout_chain", outw, {1'b1, 1'b0, 8'd3, 10'h2AA, 10'h00F});
    commit();
    pulse_trig();
    chk("hold0_c1", FruEn, 1);
    tick();
    chk("hold0_end", FruEn, 0);
    chk("hold0_armed", Armed, 1);
    shift({1'b1, 1'b1, 8'd2, 10'h2AA, 10'h00F}, outw);
    commit();
    pulse_trig();
    ones = 0;
    for (int i = 0; i < 120; i++) begin
      ones += FruEn;
      tick();
    end
    chk("sticky_120", ones, 120);
    Clear = 1;
    tick();
    Clear = 0;
    chk("clear_fru", FruEn, 0);
    chk("clear_idle", Armed, 0);
    tick();
    chk("clear_rearm", Armed, 1);
    shift({1'b1, 1'b0, 8'd50, 10'h2AA, 10'h00F}, outw);
    commit();
    pulse_trig();
    shift({1'b0, 1'b0, 8'd5, 10'h2AA, 10'h3FF}, outw);
    commit();
    chk("pend_flag", CommitPending, 1);
    chk("pend_bypass_held", BypassEn, 10'h00F);
    chk("pend_fru", FruEn, 1);
    for (int n = 0; n < 100 && FruEn; n++) tick();
    chk("pend_window_ends", FruEn, 0);
    chk("pend_applied", BypassEn, 10'h3FF);
    chk("pend_cleared", CommitPending, 0);
    chk("pend_idle", Armed, 0);
    tick();
    chk("pend_stay_idle", Armed, 0);
    shift({1'b1, 1'b0, 8'd50, 10'h155, 10'h0AA}, outw);
    commit();
    chk("cfg6_bypass", BypassEn, 10'h0AA);
    tick();
    chk("cfg6_armed", Armed, 1);
    pulse_trig();
    shift({30{1'b1}}, outw);
    commit();
    chk("rst_case_pending", CommitPending, 1);
    chk("rst_case_active", FruEn, 1);
    Rst = 1;
    tick();
    Rst = 0;
    chk("mid_rst_bypass", BypassEn, 0);
    chk("mid_rst_regconst", RegConst, 0);
    chk("mid_rst_fru", FruEn, 0);
    chk("mid_rst_armed", Armed, 0);
    chk("mid_rst_pending", CommitPending, 0);
    chk("mid_rst_cfgout", CfgOut, 0);
    shift('0, outw);
    chk("mid_rst_shadow_zero", outw, 0);
    tick();
    chk("mid_rst_stay_idle", Armed, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
